hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core; sits directly downstream of the D-stage decoder.
//  Consumes decoder Tuse_rs/Tuse_rt/D_Tnew, register fields and RegWrite, and tracks in-flight writers through E/M/W.
//  Each writer is tracked as a {A3, Tnew} record; Tnew counts down one per stage.
//  Drives stall and forwarding selects. Stall freezes PC and F/D, and bubbles D/E.
// PARAMETERS
//  REG_AW  5  register-address width
//  T_W     2  Tuse/Tnew width; value 3 = "not used / far future"
// PORTS
//  clk         in   1      core clock
//  reset       in   1      asynchronous, active-high
//  D_rs        in   5      rs field of the D instruction
//  D_rt        in   5      rt field of the D instruction
//  D_A3        in   5      destination register resolved in D (after RegDst)
//  D_RegWrite  in   1      D instruction writes the register file
//  D_Tuse_rs   in   2      cycles until rs is needed (from decoder)
//  D_Tuse_rt   in   2      cycles until rt is needed (from decoder)
//  D_Tnew      in   2      cycles until result exists, counted from D (from decoder)
//  stall       out  1      hold PC and F/D; load bubble into D/E
//  FwdD_rs     out  2      D compare/jr operand source (0 RF, 1 E, 2 M, 3 W)
//  FwdD_rt     out  2      D compare operand source (same encoding)
//  FwdE_rs     out  2      ALU A operand source (0 none, 2 M, 3 W)
//  FwdE_rt     out  2      ALU B / store-data source (0 none, 2 M, 3 W)
//  FwdM_rt     out  2      DM write-data source (0 none, 3 W)
// BEHAVIOUR
//  Records (registered): E{rs,rt,A3,Tnew}, M{rt,A3,Tnew}, W{A3,Tnew}. All are cleared to 0 on reset (async).
//  Record capture:
//    - Effective D_A3 = D_RegWrite ? D_A3 : 0. Register $0 is never a hazard or forward source.
//    - At each posedge with !stall: E <= {D_rs, D_rt, effA3, sdec(D_Tnew)}.
//    - At each posedge with stall: E <= bubble (all fields 0).
//    - M <= {E_rt, E_A3, sdec(E_Tnew)} and W <= {M_A3, sdec(M_Tnew)} every cycle; these never stall.
//    - sdec(x) = (x==0) ? 0 : x-1, saturating at 0. Example: lw D_Tnew 3 -> E 2 -> M 1 -> W 0.
//  Stall (combinational from records and D inputs):
//    stall = OR over r in {rs,rt}, S in {E,M}: (D_r != 0) && (S_A3 == D_r) && (D_Tuse_r < S_Tnew).
//  Forward (combinational):
//    - A stage is a source only if A3 != 0, A3 matches the operand and Tnew == 0.
//    - Priority is youngest first: E > M > W.
//    - FwdD considers E, M and W. FwdE considers M and W. FwdM_rt considers W only.
//    - When no source qualifies, the select is 0.
//  A stall cycle still computes forwards; the E bubble has A3=0, so it never forwards.
//  Simultaneous rs and rt hazards give a single stall. Back-to-back lw->use stalls exactly 1 cycle (Tuse 1).
//  Reset asserted mid-stall: stall drops in the same cycle as reset assertion (records zero) and all selects go to 0.
//  Latency: outputs are combinational off records. Records update one cycle after inputs.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    - Adds output perf_stall_cnt [31:0].
//    - Counts cycles with stall==1 and saturates at 32'hFFFF_FFFF.
//    - Cleared by reset.
//  HAZARD_PERF_EN undefined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package mips_defs holds:
//    - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3
//    - T_NONE=3
//    - sdec function
//    - REG_AW / T_W constants
//  Sub-module hazard_stage_reg: one async-reset record register with load-bubble control, instantiated for E, M and W.
// TESTING
//  1. lw $1 then add $2,$1,$3:
//       stall=1 for exactly 1 cycle.
//       Next cycle FwdE_rs=2? No: add sits in E while lw is in W, so FwdE_rs=3.
//  2. add $1 then beq $1,$0:
//       - D_Tuse_rs 0 vs E_Tnew 1 -> stall 1 cycle.
//       - Next cycle FwdD_rs=2 (add in M, Tnew 0).
//  3. ori $5 then sw $5,0($6):
//       - Tuse_rt 2 -> no stall.
//       - sw in E: FwdE_rt=2.
//  4. add $0,$1,$2 then add $3,$0,$0: stall=0, all Fwd*=0.
//  5. lw $4 then beq $4,$4: stall 2 cycles; then FwdD_rs=FwdD_rt=3.
//  6. reset pulse mid-stall of case 5: stall=0 immediately, records zero. HAZARD_PERF_EN: perf_stall_cnt returns to 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS pipeline definitions: forward-select encodings, writer-record
// types and the small helpers used by the hazard controller.
package mips_defs;

   localparam int REG_AW = 5;
   localparam int T_W    = 2;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   localparam logic [T_W-1:0] T_NONE = 2'd3;

   typedef logic [REG_AW-1:0] reg_t;
   typedef logic [T_W-1:0]    t_t;

   // E keeps both sources for ALU forwarding; later stages keep only what they still use.
   typedef struct packed {
      reg_t rs;
      reg_t rt;
      reg_t a3;
      t_t   tnew;
   } e_rec_t;

   typedef struct packed {
      reg_t rt;
      reg_t a3;
      t_t   tnew;
   } m_rec_t;

   typedef struct packed {
      reg_t a3;
      t_t   tnew;
   } w_rec_t;

   function automatic t_t sdec(input t_t x);
      return (x == '0) ? '0 : x - t_t'(1);
   endfunction

   function automatic logic src_hit(input reg_t r, input reg_t a3, input t_t tnew);
      return (a3 != '0) && (a3 == r) && (tnew == '0);
   endfunction

   function automatic logic need_stall(input reg_t r, input t_t tuse,
                                       input reg_t a3, input t_t tnew);
      return (r != '0) && (a3 == r) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: D-stage operand info in, stall and
// forward selects out.
interface hazard_ctrl_if;
   import mips_defs::*;

   reg_t       D_rs;
   reg_t       D_rt;
   reg_t       D_A3;
   logic       D_RegWrite;
   t_t         D_Tuse_rs;
   t_t         D_Tuse_rt;
   t_t         D_Tnew;
   logic       stall;
   logic [1:0] FwdD_rs;
   logic [1:0] FwdD_rt;
   logic [1:0] FwdE_rs;
   logic [1:0] FwdE_rt;
   logic [1:0] FwdM_rt;

   modport master (
      output D_rs, D_rt, D_A3, D_RegWrite, D_Tuse_rs, D_Tuse_rt, D_Tnew,
      input  stall, FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt
   );

   modport slave (
      input  D_rs, D_rt, D_A3, D_RegWrite, D_Tuse_rs, D_Tuse_rt, D_Tnew,
      output stall, FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt
   );

endinterface

// File: rtl/hazard_stage_reg.sv
// One in-flight writer record register; bubble loads an all-zero record,
// which can never match an operand because A3 is 0.
module hazard_stage_reg #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bubble,
   input  logic [W-1:0] rec_in,
   output logic [W-1:0] rec_q
);

   logic [W-1:0] rec_d;

   always_comb begin
      rec_d = bubble ? '0 : rec_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rec_q <= '0;
      else       rec_q <= rec_d;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W writer records and derives stall
// plus forward selects. Define HAZARD_PERF_EN to add a saturating stall counter.
module hazard_ctrl
   import mips_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt
`endif
);

   e_rec_t e_d, e_q;
   m_rec_t m_d, m_q;
   w_rec_t w_d, w_q;

   logic               stall;
   reg_t [1:0]         d_op;
   t_t   [1:0]         d_tuse;
   logic [1:0]         op_stall;
   logic [1:0][1:0]    fwd_d;

   // Writes to $0 are dropped here so nothing downstream ever matches them.
   always_comb begin
      e_d      = '0;
      e_d.rs   = hif.D_rs;
      e_d.rt   = hif.D_rt;
      e_d.a3   = hif.D_RegWrite ? hif.D_A3 : '0;
      e_d.tnew = sdec(hif.D_Tnew);
      m_d      = '{rt: e_q.rt, a3: e_q.a3, tnew: sdec(e_q.tnew)};
      w_d      = '{a3: m_q.a3, tnew: sdec(m_q.tnew)};
   end

   hazard_stage_reg #(.W($bits(e_rec_t))) u_e_rec (
      .clk(clk), .reset(reset), .bubble(stall), .rec_in(e_d), .rec_q(e_q)
   );

   hazard_stage_reg #(.W($bits(m_rec_t))) u_m_rec (
      .clk(clk), .reset(reset), .bubble(1'b0), .rec_in(m_d), .rec_q(m_q)
   );

   hazard_stage_reg #(.W($bits(w_rec_t))) u_w_rec (
      .clk(clk), .reset(reset), .bubble(1'b0), .rec_in(w_d), .rec_q(w_q)
   );

   assign d_op   = {hif.D_rt, hif.D_rs};
   assign d_tuse = {hif.D_Tuse_rt, hif.D_Tuse_rs};

   // Per-operand D-stage logic: index 0 is rs, index 1 is rt.
   for (genvar i = 0; i < 2; i++) begin : g_dop
      always_comb begin
         op_stall[i] = need_stall(d_op[i], d_tuse[i], e_q.a3, e_q.tnew) ||
                       need_stall(d_op[i], d_tuse[i], m_q.a3, m_q.tnew);
         fwd_d[i]    = FWD_RF;
         if      (src_hit(d_op[i], e_q.a3, e_q.tnew)) fwd_d[i] = FWD_E;
         else if (src_hit(d_op[i], m_q.a3, m_q.tnew)) fwd_d[i] = FWD_M;
         else if (src_hit(d_op[i], w_q.a3, w_q.tnew)) fwd_d[i] = FWD_W;
      end
   end

   assign stall = |op_stall;

   always_comb begin
      hif.stall   = stall;
      hif.FwdD_rs = fwd_d[0];
      hif.FwdD_rt = fwd_d[1];

      hif.FwdE_rs = FWD_RF;
      if      (src_hit(e_q.rs, m_q.a3, m_q.tnew)) hif.FwdE_rs = FWD_M;
      else if (src_hit(e_q.rs, w_q.a3, w_q.tnew)) hif.FwdE_rs = FWD_W;

      hif.FwdE_rt = FWD_RF;
      if      (src_hit(e_q.rt, m_q.a3, m_q.tnew)) hif.FwdE_rt = FWD_M;
      else if (src_hit(e_q.rt, w_q.a3, w_q.tnew)) hif.FwdE_rt = FWD_W;

      hif.FwdM_rt = FWD_RF;
      if (src_hit(m_q.rt, w_q.a3, w_q.tnew)) hif.FwdM_rt = FWD_W;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_cnt_d, perf_cnt_q;

   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (stall && (perf_cnt_q != 32'hFFFF_FFFF)) perf_cnt_d = perf_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) perf_cnt_q <= '0;
      else       perf_cnt_q <= perf_cnt_d;
   end

   assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected values are hand-derived
// from the record pipeline (D Tnew -> E -> M -> W, one decrement per stage).
module tb_hazard_ctrl;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt;
   hazard_ctrl dut (.clk(clk), .reset(reset), .hif(hif), .perf_stall_cnt(perf_stall_cnt));
`else
   hazard_ctrl dut (.clk(clk), .reset(reset), .hif(hif));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic set_d(input int rs, input int rt, input int a3, input int rw,
                        input int tu_rs, input int tu_rt, input int tnew);
      hif.D_rs       = 5'(rs);
      hif.D_rt       = 5'(rt);
      hif.D_A3       = 5'(a3);
      hif.D_RegWrite = 1'(rw);
      hif.D_Tuse_rs  = 2'(tu_rs);
      hif.D_Tuse_rt  = 2'(tu_rt);
      hif.D_Tnew     = 2'(tnew);
   endtask

   task automatic nop();
      set_d(0, 0, 0, 0, 3, 3, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      set_d(4, 4, 0, 0, 0, 0, 0);
      #2;
      chk("rst_stall", hif.stall, 0);
      chk("rst_fwdd_rs", hif.FwdD_rs, 0);
      chk("rst_fwdd_rt", hif.FwdD_rt, 0);
      chk("rst_fwde_rs", hif.FwdE_rs, 0);
      chk("rst_fwdm_rt", hif.FwdM_rt, 0);
      #10;
      reset = 1'b0;
      flush();

      // lw $1,0($2) then add $2,$1,$3
      set_d(2, 1, 1, 1, 1, 3, 3);
      #1 chk("c1_lw_nostall", hif.stall, 0);
      tick();
      set_d(1, 3, 2, 1, 1, 1, 2);
      #1 chk("c1_stall", hif.stall, 1);
      tick();
      chk("c1_release", hif.stall, 0);
      chk("c1_fwdd_rs", hif.FwdD_rs, 0);
      tick();
      nop();
      #1 chk("c1_fwde_rs", hif.FwdE_rs, 3);
      chk("c1_fwde_rt", hif.FwdE_rt, 0);
      flush();

      // add $1,$2,$3 then beq $1,$0
      set_d(2, 3, 1, 1, 1, 1, 2);
      tick();
      set_d(1, 0, 0, 0, 0, 0, 0);
      #1 chk("c2_stall", hif.stall, 1);
      tick();
      chk("c2_release", hif.stall, 0);
      chk("c2_fwdd_rs", hif.FwdD_rs, 2);
      chk("c2_fwdd_rt", hif.FwdD_rt, 0);
      flush();

      // ori $5 then sw $5,0($6)
      set_d(0, 5, 5, 1, 1, 3, 2);
      tick();
      set_d(6, 5, 0, 0, 1, 2, 0);
      #1 chk("c3_nostall", hif.stall, 0);
      chk("c3_fwdd_rt", hif.FwdD_rt, 0);
      tick();
      nop();
      #1 chk("c3_fwde_rt", hif.FwdE_rt, 2);
      chk("c3_fwde_rs", hif.FwdE_rs, 0);
      tick();
      chk("c3_fwdm_rt", hif.FwdM_rt, 3);
      flush();

      // add $0,$1,$2 then add $3,$0,$0
      set_d(1, 2, 0, 1, 1, 1, 2);
      tick();
      set_d(0, 0, 3, 1, 1, 1, 2);
      #1 chk("c4_nostall", hif.stall, 0);
      chk("c4_fwdd_rs", hif.FwdD_rs, 0);
      chk("c4_fwdd_rt", hif.FwdD_rt, 0);
      tick();
      nop();
      #1 chk("c4_fwde_rs", hif.FwdE_rs, 0);
      chk("c4_fwde_rt", hif.FwdE_rt, 0);
      flush();

      // non-writing instruction with a stale A3 field must not be a hazard
      set_d(0, 0, 9, 0, 3, 3, 2);
      tick();
      set_d(9, 9, 0, 0, 0, 0, 0);
      #1 chk("rw0_nostall", hif.stall, 0);
      flush();

      // two writers of $7 (Tnew 1) then beq $7: youngest source wins
      set_d(0, 0, 7, 1, 3, 3, 1);
      tick();
      tick();
      set_d(7, 0, 0, 0, 0, 0, 0);
      #1 chk("pri_nostall", hif.stall, 0);
      chk("pri_fwd_e", hif.FwdD_rs, 1);
      tick();
      chk("pri_fwd_m", hif.FwdD_rs, 2);
      tick();
      chk("pri_fwd_w", hif.FwdD_rs, 3);
      flush();

      // lw $4 then beq $4,$4: two stall cycles
      set_d(2, 4, 4, 1, 1, 3, 3);
      tick();
      set_d(4, 4, 0, 0, 0, 0, 0);
      #1 chk("c5_stall1", hif.stall, 1);
      tick();
      chk("c5_stall2", hif.stall, 1);
      tick();
      chk("c5_release", hif.stall, 0);
      chk("c5_fwdd_rs", hif.FwdD_rs, 3);
      chk("c5_fwdd_rt", hif.FwdD_rt, 3);
      flush();
`ifdef HAZARD_PERF_EN
      chk("perf_cnt", perf_stall_cnt, 4);
`endif

      // reset asserted in the middle of the lw->beq stall
      set_d(2, 4, 4, 1, 1, 3, 3);
      tick();
      set_d(4, 4, 0, 0, 0, 0, 0);
      #1 chk("c6_stall", hif.stall, 1);
      #2 reset = 1'b1;
      #1 chk("c6_rst_stall", hif.stall, 0);
      chk("c6_rst_fwdd_rs", hif.FwdD_rs, 0);
      chk("c6_rst_fwdd_rt", hif.FwdD_rt, 0);
      chk("c6_rst_fwde_rs", hif.FwdE_rs, 0);
`ifdef HAZARD_PERF_EN
      chk("c6_perf_clr", perf_stall_cnt, 0);
`endif
      tick();
      chk("c6_rst_hold", hif.stall, 0);
      reset = 1'b0;
      #1 chk("c6_post_rst", hif.stall, 0);
      tick();
      chk("c6_post_cap", hif.stall, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
